// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with write-back bypass and a
// per-register pending-write scoreboard, loaded by an init sequencer after reset.
// Latency: reads are combinational; writes and scoreboard updates land at the next posedge.
// Flow control: no backpressure. wb_en/iss_en are ignored until ready=1.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rd_addr / rd_data   NUM_RD packed read ports (port i at [i*W +: W])
//   rd_busy             per-port pending-write flag for the addressed register
//   wb_en/addr/data     write-back port (also clears the pending bit)
//   iss_en/iss_addr     issue port (sets the pending bit)
//   busy_vec            full scoreboard, bit a = register a pending
//   ready               init sequence finished
module reg_file_mp #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int NUM_RD    = 2,
  parameter int INIT_MODE = 1,
  parameter int BYPASS    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [DEPTH-1:0]           busy_vec,
  output logic                       ready
);

  // Counter only has to reach DEPTH-1; keep at least one bit for DEPTH=1.
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    init_cnt, init_cnt_d;
  logic [DEPTH-1:0]    busy_q, busy_d;

  // Storage has no reset: the init sequencer provides the reset contents.
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                wb_ok;
  logic                iss_ok;

  assign ready    = (state_q == RUN);
  assign busy_vec = busy_q;

  // Out-of-range destinations are dropped; nothing is accepted before ready.
  assign wb_ok  = ready && wb_en  && (int'(wb_addr)  < DEPTH);
  assign iss_ok = ready && iss_en && (int'(iss_addr) < DEPTH);

  // ---------------------------------------------------------------------------
  // Init / run FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      init_cnt <= '0;
    end else begin
      state_q  <= state_d;
      init_cnt <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt + 1'b1;
        if (init_cnt == LAST_IDX) begin
          state_d    = RUN;
          init_cnt_d = init_cnt;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Array write port: shared between the init sequencer and write-back
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = ADDR_W'(init_cnt);
      mem_wdata = (INIT_MODE == 1) ? DATA_W'(init_cnt) : '0;
    end else if (wb_ok) begin
      mem_we    = 1'b1;
      mem_waddr = wb_addr;
      mem_wdata = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: clear on write-back, then set on issue so a new producer
  // issued in the same cycle as the old one retires keeps the bit set.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    for (int a = 0; a < DEPTH; a++) begin
      if (wb_ok && (wb_addr == ADDR_W'(a))) begin
        busy_d[a] = 1'b0;
      end
      if (iss_ok && (iss_addr == ADDR_W'(a))) begin
        busy_d[a] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      automatic logic [ADDR_W-1:0] ra = rd_addr[i*ADDR_W +: ADDR_W];
      if (ready && (int'(ra) < DEPTH)) begin
        rd_data[i*DATA_W +: DATA_W] = mem[ra];
        rd_busy[i]                  = busy_q[ra];
        // A write-back in flight to the same register supplies the value,
        // so the consumer need not wait for it.
        if ((BYPASS == 1) && wb_en && (wb_addr == ra)) begin
          rd_data[i*DATA_W +: DATA_W] = wb_data;
          rd_busy[i]                  = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  logic        clk;
  logic        rst;

  // Instance A: default parameters (DEPTH=16, INIT_MODE=1, BYPASS=1)
  logic [7:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic        wb_en_a;
  logic [3:0]  wb_addr_a;
  logic [31:0] wb_data_a;
  logic        iss_en_a;
  logic [3:0]  iss_addr_a;
  logic [15:0] busy_vec_a;
  logic        ready_a;

  // Instance B: DEPTH=12, INIT_MODE=0, BYPASS=0
  logic [7:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic        wb_en_b;
  logic [3:0]  wb_addr_b;
  logic [31:0] wb_data_b;
  logic        iss_en_b;
  logic [3:0]  iss_addr_b;
  logic [11:0] busy_vec_b;
  logic        ready_b;

  int n_checks = 0;
  int n_fail   = 0;
  int wait_cnt;

  reg_file_mp u_a (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr_a),
    .rd_data  (rd_data_a),
    .rd_busy  (rd_busy_a),
    .wb_en    (wb_en_a),
    .wb_addr  (wb_addr_a),
    .wb_data  (wb_data_a),
    .iss_en   (iss_en_a),
    .iss_addr (iss_addr_a),
    .busy_vec (busy_vec_a),
    .ready    (ready_a)
  );

  reg_file_mp #(
    .DATA_W(32), .ADDR_W(4), .DEPTH(12), .NUM_RD(2), .INIT_MODE(0), .BYPASS(0)
  ) u_b (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr_b),
    .rd_data  (rd_data_b),
    .rd_busy  (rd_busy_b),
    .wb_en    (wb_en_b),
    .wb_addr  (wb_addr_b),
    .wb_data  (wb_data_b),
    .iss_en   (iss_en_b),
    .iss_addr (iss_addr_b),
    .busy_vec (busy_vec_b),
    .ready    (ready_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    rd_addr_a  = {4'd0, 4'd5};
    wb_en_a    = 1'b0; wb_addr_a = '0; wb_data_a = '0;
    iss_en_a   = 1'b0; iss_addr_a = '0;
    rd_addr_b  = {4'd13, 4'd0};
    wb_en_b    = 1'b0; wb_addr_b = '0; wb_data_b = '0;
    iss_en_b   = 1'b0; iss_addr_b = '0;
    tick();
    tick();

    // Reset state
    check("rst_ready_a",   {63'd0, ready_a}, 64'd0);
    check("rst_busy_a",    {48'd0, busy_vec_a}, 64'd0);
    check("rst_rdata_a",   rd_data_a, 64'd0);
    check("rst_ready_b",   {63'd0, ready_b}, 64'd0);

    // Release reset with writes/issues pending; all must be ignored during INIT
    wb_en_a = 1'b1; wb_addr_a = 4'd0; wb_data_a = 32'hFF;
    iss_en_a = 1'b1; iss_addr_a = 4'd6;
    wb_en_b = 1'b1; wb_addr_b = 4'd0; wb_data_b = 32'hFF;
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5)  wb_en_b = 1'b0;
      if (k == 11) check("init_b_not_ready_11", {63'd0, ready_b}, 64'd0);
      if (k == 12) check("init_b_ready_12",     {63'd0, ready_b}, 64'd1);
      if (k == 14) begin
        wb_en_a  = 1'b0;
        iss_en_a = 1'b0;
      end
      if (k == 15) begin
        check("init_a_not_ready_15", {63'd0, ready_a}, 64'd0);
        check("init_a_rdata_zero",   rd_data_a, 64'd0);
        check("init_a_rdbusy_zero",  {62'd0, rd_busy_a}, 64'd0);
      end
      if (k == 16) check("init_a_ready_16", {63'd0, ready_a}, 64'd1);
    end

    // Defaults after init: entry i holds i; r0 kept its init value; issue ignored
    check("def_r5_r0",  rd_data_a, {32'd0, 32'd5});
    check("def_busy_a", {48'd0, busy_vec_a}, 64'd0);
    rd_addr_a = {4'd15, 4'd6};
    #1;
    check("def_r6_r15", rd_data_a, {32'd15, 32'd6});

    // INIT_MODE=0 instance: every entry reads zero
    for (int a = 0; a < 12; a++) begin
      rd_addr_b = {4'd13, 4'(a)};
      #1;
      check($sformatf("b_zero_r%0d", a), rd_data_b, 64'd0);
    end
    check("b_oor_busy", {62'd0, rd_busy_b}, 64'd0);

    // Write then read on both ports
    rd_addr_a = 8'h00;
    wb_en_a = 1'b1; wb_addr_a = 4'd3; wb_data_a = 32'hDEADBEEF;
    tick();
    wb_en_a = 1'b0;
    rd_addr_a = {4'd3, 4'd3};
    #1;
    check("wr_rd_both_r3", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});

    // Bypass with r7 pending
    rd_addr_a = 8'h00;
    iss_en_a = 1'b1; iss_addr_a = 4'd7;
    tick();
    iss_en_a = 1'b0;
    check("byp_iss_r7", {48'd0, busy_vec_a}, 64'h0080);
    wb_en_a = 1'b1; wb_addr_a = 4'd7; wb_data_a = 32'h1234;
    rd_addr_a = {4'd0, 4'd7};
    #1;
    check("byp_data0",  {32'd0, rd_data_a[31:0]}, 64'h1234);
    check("byp_busy0",  {62'd0, rd_busy_a}, 64'd0);
    check("byp_vec_still", {48'd0, busy_vec_a}, 64'h0080);
    tick();
    wb_en_a = 1'b0;
    #1;
    check("byp_after_vec",  {48'd0, busy_vec_a}, 64'd0);
    check("byp_after_data", {32'd0, rd_data_a[31:0]}, 64'h1234);

    // No bypass: old value and busy state visible
    iss_en_b = 1'b1; iss_addr_b = 4'd7;
    tick();
    iss_en_b = 1'b0;
    wb_en_b = 1'b1; wb_addr_b = 4'd7; wb_data_b = 32'h1234;
    rd_addr_b = {4'd13, 4'd7};
    #1;
    check("nobyp_data0", rd_data_b, 64'd0);
    check("nobyp_busy",  {62'd0, rd_busy_b}, 64'd1);
    tick();
    wb_en_b = 1'b0;
    #1;
    check("nobyp_after_data", rd_data_b, {32'd0, 32'h1234});
    check("nobyp_after_busy", {62'd0, rd_busy_b}, 64'd0);

    // Scoreboard
    iss_en_a = 1'b1; iss_addr_a = 4'd2;
    tick();
    iss_en_a = 1'b0;
    rd_addr_a = {4'd2, 4'd0};
    #1;
    check("sb_iss_vec",   {48'd0, busy_vec_a}, 64'h0004);
    check("sb_iss_rbusy", {62'd0, rd_busy_a}, 64'd2);
    wb_en_a = 1'b1; wb_addr_a = 4'd2; wb_data_a = 32'h22;
    #1;
    check("sb_wb_fwd_busy", {62'd0, rd_busy_a}, 64'd0);
    check("sb_wb_fwd_data", {32'd0, rd_data_a[63:32]}, 64'h22);
    tick();
    wb_en_a = 1'b0;
    check("sb_wb_clear", {48'd0, busy_vec_a}, 64'd0);
    iss_en_a = 1'b1; iss_addr_a = 4'd2;
    wb_en_a = 1'b1; wb_addr_a = 4'd2; wb_data_a = 32'h33;
    tick();
    iss_en_a = 1'b0; wb_en_a = 1'b0;
    #1;
    check("sb_both_set_wins", {48'd0, busy_vec_a}, 64'h0004);
    check("sb_both_data",     {32'd0, rd_data_a[63:32]}, 64'h33);
    iss_en_a = 1'b1; iss_addr_a = 4'd2;
    tick();
    iss_en_a = 1'b0;
    check("sb_reissue", {48'd0, busy_vec_a}, 64'h0004);
    wb_en_a = 1'b1; wb_addr_a = 4'd2; wb_data_a = 32'h44;
    tick();
    wb_en_a = 1'b0;
    check("sb_final_clear", {48'd0, busy_vec_a}, 64'd0);

    // Out-of-range address on DEPTH=12: write and issue dropped, read is zero
    wb_en_b = 1'b1; wb_addr_b = 4'd13; wb_data_b = 32'hAB;
    iss_en_b = 1'b1; iss_addr_b = 4'd13;
    rd_addr_b = {4'd13, 4'd1};
    tick();
    wb_en_b = 1'b0; iss_en_b = 1'b0;
    #1;
    check("oor_busy_vec", {52'd0, busy_vec_b}, 64'd0);
    check("oor_rdata",    rd_data_b, 64'd0);
    check("oor_rbusy",    {62'd0, rd_busy_b}, 64'd0);

    // Mid-operation reset
    iss_en_a = 1'b1; iss_addr_a = 4'd1;
    wb_en_a = 1'b1; wb_addr_a = 4'd4; wb_data_a = 32'hAA;
    tick();
    iss_en_a = 1'b0; wb_en_a = 1'b0;
    rd_addr_a = {4'd3, 4'd4};
    #1;
    check("mid_busy_r1", {48'd0, busy_vec_a}, 64'h0002);
    check("mid_r4_aa",   {32'd0, rd_data_a[31:0]}, 64'hAA);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  {48'd0, busy_vec_a}, 64'd0);
    check("mid_rst_ready", {63'd0, ready_a}, 64'd0);
    tick();
    rst = 1'b0;
    wait_cnt = 0;
    while (!ready_a && wait_cnt < 40) begin
      tick();
      wait_cnt++;
    end
    check("reinit_cycles", 64'(wait_cnt), 64'd16);
    check("reinit_r4_r3",  rd_data_a, {32'd3, 32'd4});
    check("reinit_ready_b", {63'd0, ready_b}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
